// File: rtl/user_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// user_gpio_ctrl
//
// Eight-bit general purpose I/O block behind a zero-wait AHB-lite slave port.
//
// Register map (byte offset, HADDR[4:2] selects the register):
//   0x00 DATA_IN     RO   synchronized pad inputs
//   0x04 DATA_OUT    RW   pad drive value
//   0x08 OEB         RW   1 = pad tristated
//   0x0C IRQ_EN      RW   per-bit interrupt enable
//   0x10 IRQ_RISE    RW   1 = rising edge, 0 = falling edge
//   0x14 IRQ_STATUS  W1C  sticky edge flags
//   0x18 OUT_SET     WO   DATA_OUT |= data   (reads 0)
//   0x1C OUT_CLR     WO   DATA_OUT &= ~data  (reads 0)
//
// Only HWDATA[7:0] is used, and a write is applied only when the byte offset
// HADDR[1:0] of its address phase was zero. HSIZE is accepted but ignored.
//
// Build option:
//   USER_GPIO_CTRL_IRQ_EN  when defined, the interrupt logic (IRQ_EN,
//                          IRQ_RISE, IRQ_STATUS, edge detector) is built.
//                          When undefined, offsets 0x0C-0x14 read as zero,
//                          writes there are dropped and user_irq is tied low.
//
// Parameter SYNC_STAGES sets the depth of the input synchronizer; the legal
// range is 2..4.
// -----------------------------------------------------------------------------
module user_gpio_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,

    // AHB-lite slave port
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,

    // Pads
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic [7:0]  gpio_oeb,

    // Level interrupt to the management core
    output logic        user_irq
);

    // -------------------------------------------------------------------------
    // Register selector, taken from HADDR[4:2]
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        REG_DATA_IN    = 3'd0,
        REG_DATA_OUT   = 3'd1,
        REG_OEB        = 3'd2,
        REG_IRQ_EN     = 3'd3,
        REG_IRQ_RISE   = 3'd4,
        REG_IRQ_STATUS = 3'd5,
        REG_OUT_SET    = 3'd6,
        REG_OUT_CLR    = 3'd7
    } reg_sel_e;

    // -------------------------------------------------------------------------
    // AHB address phase capture
    // -------------------------------------------------------------------------
    logic       addr_valid;  // a real transfer is addressing this slave
    logic       dp_valid;    // a data phase for this slave is in progress
    logic       dp_write;    // that data phase is a write
    reg_sel_e   dp_sel;      // register addressed by that data phase
    logic [1:0] dp_byte;     // byte offset captured from HADDR[1:0]

    // IDLE and BUSY have HTRANS[1] == 0 and never open a data phase.
    assign addr_valid = HSEL & HREADY & HTRANS[1];

    // Capture the address phase so the data phase knows what to do.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            // NOTE: sequential state is always assigned non-blocking, so every
            // flop in the design samples pre-edge values regardless of the
            // order in which the simulator evaluates the blocks.
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_sel   <= REG_DATA_IN;
            dp_byte  <= 2'b00;
        end else begin
            dp_valid <= addr_valid;
            if (addr_valid) begin
                dp_write <= HWRITE;
                dp_sel   <= reg_sel_e'(HADDR[4:2]);
                dp_byte  <= HADDR[1:0];
            end
        end
    end

    // The slave never stalls.
    assign HREADYOUT = 1'b1;

    // -------------------------------------------------------------------------
    // Write strobes, valid during the data phase; the registers update on the
    // edge that ends it. A reset during the data phase drops the write because
    // dp_valid is cleared asynchronously.
    // -------------------------------------------------------------------------
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_data_out;
    logic       wr_oeb;
    logic       wr_out_set;
    logic       wr_out_clr;

    assign wr_en       = dp_valid & dp_write & (dp_byte == 2'b00);
    assign wr_data     = HWDATA[7:0];
    assign wr_data_out = wr_en & (dp_sel == REG_DATA_OUT);
    assign wr_oeb      = wr_en & (dp_sel == REG_OEB);
    assign wr_out_set  = wr_en & (dp_sel == REG_OUT_SET);
    assign wr_out_clr  = wr_en & (dp_sel == REG_OUT_CLR);

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic [7:0] data_out;
    logic [7:0] oeb;

    // DATA_OUT: direct write, or bitwise set/clear through the alias offsets.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_out <= 8'h00;
        end else if (wr_data_out) begin
            data_out <= wr_data;
        end else if (wr_out_set) begin
            data_out <= data_out | wr_data;
        end else if (wr_out_clr) begin
            data_out <= data_out & ~wr_data;
        end
    end

    // OEB: all pads tristated out of reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            oeb <= 8'hFF;
        end else if (wr_oeb) begin
            oeb <= wr_data;
        end
    end

    assign gpio_out = data_out;
    assign gpio_oeb = oeb;

    // -------------------------------------------------------------------------
    // Input synchronizer: SYNC_STAGES flops per pad bit, last stage is DATA_IN
    // -------------------------------------------------------------------------
    logic [7:0] sync_ff [SYNC_STAGES];
    logic [7:0] sync_in;

    // Shift pad samples through the synchronizer chain.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            // NOTE: this array is a chain of flops rather than a memory, so it
            // is cleared element by element along with the other state.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= 8'h00;
            end
        end else begin
            sync_ff[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign sync_in = sync_ff[SYNC_STAGES-1];

`ifdef USER_GPIO_CTRL_IRQ_EN
    // -------------------------------------------------------------------------
    // Interrupt logic
    // -------------------------------------------------------------------------
    logic       wr_irq_en;
    logic       wr_irq_rise;
    logic       wr_irq_status;
    logic [7:0] irq_en;
    logic [7:0] irq_rise;
    logic [7:0] irq_status;
    logic [7:0] prev_in;   // synchronized input one cycle ago
    logic [7:0] edge_det;  // per-bit edge of the selected polarity
    logic [7:0] w1c_mask;

    assign wr_irq_en     = wr_en & (dp_sel == REG_IRQ_EN);
    assign wr_irq_rise   = wr_en & (dp_sel == REG_IRQ_RISE);
    assign wr_irq_status = wr_en & (dp_sel == REG_IRQ_STATUS);

    // Enable and polarity configuration.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_en   <= 8'h00;
            irq_rise <= 8'h00;
        end else begin
            if (wr_irq_en) begin
                irq_en <= wr_data;
            end
            if (wr_irq_rise) begin
                irq_rise <= wr_data;
            end
        end
    end

    // Delayed copy of the synchronized input. Reset to zero, so a pin that is
    // already high when reset releases shows up as a rising edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            prev_in <= 8'h00;
        end else begin
            prev_in <= sync_in;
        end
    end

    // Edges come only from input transitions: changing irq_rise while the
    // input is steady leaves sync_in == prev_in, so both terms stay zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        edge_det = 8'h00;
        w1c_mask = 8'h00;
        edge_det = ( irq_rise &  sync_in & ~prev_in)
                 | (~irq_rise & ~sync_in &  prev_in);
        if (wr_irq_status) begin
            w1c_mask = wr_data;
        end
    end

    // Sticky status: the clear is applied first and the new edge ORed in
    // afterwards, so a coincident edge wins over a write-one-to-clear.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_status <= 8'h00;
        end else begin
            irq_status <= (irq_status & ~w1c_mask) | edge_det;
        end
    end

    // Level interrupt straight from the registers.
    assign user_irq = |(irq_status & irq_en);
`else
    // Interrupt logic not built: the line stays low.
    assign user_irq = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read data: driven in the data phase from current register state. A read
    // right behind a write to the same register sees the new value because the
    // write lands on the edge that starts the read's data phase.
    // -------------------------------------------------------------------------
    logic [7:0] rd_byte;

    // Read multiplexer.
    always_comb begin
        rd_byte = 8'h00;
        if (dp_valid && !dp_write) begin
            case (dp_sel)
                REG_DATA_IN:    rd_byte = sync_in;
                REG_DATA_OUT:   rd_byte = data_out;
                REG_OEB:        rd_byte = oeb;
`ifdef USER_GPIO_CTRL_IRQ_EN
                REG_IRQ_EN:     rd_byte = irq_en;
                REG_IRQ_RISE:   rd_byte = irq_rise;
                REG_IRQ_STATUS: rd_byte = irq_status;
`endif
                default:        rd_byte = 8'h00;
            endcase
        end
    end

    assign HRDATA = {24'h000000, rd_byte};

    // Bus bits with no function in this block.
    logic unused_bus_bits;
    assign unused_bus_bits = &{1'b0, HSIZE, HTRANS[0], HADDR[31:5], HWDATA[31:8]};

endmodule

// File: tb/tb_user_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_user_gpio_ctrl
//
// Directed steps followed by randomized AHB traffic and pad activity. The
// reference model works at the transfer level: register values as plain
// variables, and the pad synchronizer as a history queue of pad samples taken
// at each clock edge. Works with and without USER_GPIO_CTRL_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_user_gpio_ctrl;

    localparam int S = 2;

`ifdef USER_GPIO_CTRL_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oeb;
    logic        user_irq;

    user_gpio_ctrl #(.SYNC_STAGES(S)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .user_irq  (user_irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] m_out;
    logic [7:0] m_oeb;
    logic [7:0] m_en;
    logic [7:0] m_rise;
    logic [7:0] m_stat;
    logic [7:0] hist[$];   // hist[0] = pads sampled at the most recent edge
    logic       p_valid;
    logic       p_wr;
    logic [4:0] p_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out   = 8'h00;
        m_oeb   = 8'hFF;
        m_en    = 8'h00;
        m_rise  = 8'h00;
        m_stat  = 8'h00;
        p_valid = 1'b0;
        p_wr    = 1'b0;
        p_addr  = 5'd0;
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back(8'h00);
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return hist[S-1];
            3'd1:    return m_out;
            3'd2:    return m_oeb;
            3'd3:    return HAS_IRQ ? m_en   : 8'h00;
            3'd4:    return HAS_IRQ ? m_rise : 8'h00;
            3'd5:    return HAS_IRQ ? m_stat : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // One bus cycle: drives an address phase (sel/trans/rdy/addr/wr) plus the
    // write data belonging to the previous address phase, advances the model
    // across the clock edge and checks the outputs mid-cycle.
    task automatic step(input logic sel, input logic [1:0] trans, input logic rdy,
                        input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        logic [7:0] a, b, det, w1c, d;
        HSEL   = sel;
        HTRANS = trans;
        HREADY = rdy;
        HADDR  = addr;
        HWRITE = wr;
        HWDATA = wdata;
        HSIZE  = 3'($urandom_range(0, 2));
        @(posedge HCLK);
        hist.push_front(gpio_in);
        // Synchronized value before this edge = pads S edges ago; the copy
        // one cycle older is the edge reference.
        a = hist[S];
        b = hist[S+1];
        void'(hist.pop_back());
        det = HAS_IRQ ? ((m_rise & a & ~b) | (~m_rise & ~a & b)) : 8'h00;
        w1c = 8'h00;
        d   = wdata[7:0];
        if (p_valid && p_wr && p_addr[1:0] == 2'b00) begin
            case (p_addr[4:2])
                3'd1: m_out = d;
                3'd2: m_oeb = d;
                3'd3: if (HAS_IRQ) m_en = d;
                3'd4: if (HAS_IRQ) m_rise = d;
                3'd5: w1c = d;
                3'd6: m_out = m_out | d;
                3'd7: m_out = m_out & ~d;
                default: ;
            endcase
        end
        if (HAS_IRQ) m_stat = (m_stat & ~w1c) | det;
        p_valid = sel & rdy & trans[1];
        if (p_valid) begin
            p_wr   = wr;
            p_addr = addr[4:0];
        end
        #4;
        check("gpio_out", 32'(gpio_out), 32'(m_out));
        check("gpio_oeb", 32'(gpio_oeb), 32'(m_oeb));
        check("user_irq", 32'(user_irq), HAS_IRQ ? 32'(|(m_stat & m_en)) : 32'd0);
        check("hreadyout", 32'(HREADYOUT), 32'd1);
        if (p_valid && !p_wr)
            check("hrdata", HRDATA, {24'h0, m_read(p_addr[4:2])});
    endtask

    task automatic idle(input logic [31:0] wdata);
        step(1'b0, 2'b00, 1'b1, 32'h0, 1'b0, wdata);
    endtask

    task automatic wr_op(input logic [31:0] addr, input logic [7:0] data);
        step(1'b1, 2'b10, 1'b1, addr, 1'b1, 32'h0);
        idle({24'h0, data});
    endtask

    task automatic rd_op(input logic [31:0] addr, output logic [31:0] val);
        step(1'b1, 2'b10, 1'b1, addr, 1'b0, 32'h0);
        val = HRDATA;
        idle(32'h0);
    endtask

    initial begin
        logic [31:0] v;
        logic        r_sel;
        logic        r_wr;
        logic        r_rdy;
        logic [1:0]  r_trans;
        logic [1:0]  r_off;
        logic [2:0]  r_idx;

        HRESET  = 1'b1;
        HSEL    = 1'b0;
        HADDR   = 32'h0;
        HWDATA  = 32'h0;
        HREADY  = 1'b1;
        HWRITE  = 1'b0;
        HTRANS  = 2'b00;
        HSIZE   = 3'd2;
        gpio_in = 8'h00;
        model_reset();

        // Reset state
        repeat (2) @(posedge HCLK);
        #4;
        check("rst_gpio_out", 32'(gpio_out), 32'h00);
        check("rst_gpio_oeb", 32'(gpio_oeb), 32'hFF);
        check("rst_user_irq", 32'(user_irq), 32'd0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        HRESET = 1'b0;

        // Back-to-back DATA_OUT write, OUT_SET, OUT_CLR, then read
        step(1'b1, 2'b10, 1'b1, 32'h04, 1'b1, 32'h0);
        step(1'b1, 2'b10, 1'b1, 32'h18, 1'b1, 32'h5A);
        check("b2b_write", 32'(gpio_out), 32'h5A);
        step(1'b1, 2'b10, 1'b1, 32'h1C, 1'b1, 32'h81);
        check("b2b_set", 32'(gpio_out), 32'hDB);
        step(1'b1, 2'b10, 1'b1, 32'h04, 1'b0, 32'h02);
        check("b2b_clr", 32'(gpio_out), 32'hD9);
        check("b2b_read", HRDATA, 32'hD9);
        idle(32'h0);

        // OEB write followed immediately by a read of the same register
        step(1'b1, 2'b10, 1'b1, 32'h08, 1'b1, 32'h0);
        step(1'b1, 2'b10, 1'b1, 32'h08, 1'b0, 32'h0F);
        check("oeb_wr_rd", HRDATA, 32'h0000000F);
        check("oeb_pads", 32'(gpio_oeb), 32'h0F);
        idle(32'h0);

        // Set/clear reads back zero, non-zero byte offset write is ignored
        rd_op(32'h18, v);
        check("out_set_rd", v, 32'h0);
        wr_op(32'h05, 8'hFF);
        rd_op(32'h04, v);
        check("byte_off_wr", v, 32'hD9);

`ifdef USER_GPIO_CTRL_IRQ_EN
        // Rising edge on bit 0 raises status and user_irq after S+1 edges
        wr_op(32'h10, 8'h01);
        wr_op(32'h0C, 8'h01);
        gpio_in = 8'h01;
        repeat (S) idle(32'h0);
        check("irq_not_yet", 32'(user_irq), 32'd0);
        idle(32'h0);
        check("irq_rise0", 32'(user_irq), 32'd1);
        rd_op(32'h14, v);
        check("stat_rise0", v, 32'h01);

        // Rise on bit 1 with falling polarity is not an event
        gpio_in = 8'h03;
        repeat (S + 2) idle(32'h0);
        rd_op(32'h14, v);
        check("stat_bit1_rise", v, 32'h01);

        // Fall then rise on bit 0; the W1C lands on the same edge as detection
        gpio_in = 8'h02;
        repeat (S + 2) idle(32'h0);
        gpio_in = 8'h03;
        repeat (S - 1) idle(32'h0);
        step(1'b1, 2'b10, 1'b1, 32'h14, 1'b1, 32'h0);
        idle(32'h01);
        check("w1c_vs_edge_irq", 32'(user_irq), 32'd1);
        rd_op(32'h14, v);
        check("w1c_vs_edge_stat", v, 32'h01);
        wr_op(32'h14, 8'h01);
        check("w1c_irq", 32'(user_irq), 32'd0);
        rd_op(32'h14, v);
        check("w1c_stat", v, 32'h00);

        // Polarity change alone does not create an edge
        wr_op(32'h10, 8'h00);
        repeat (S + 2) idle(32'h0);
        rd_op(32'h14, v);
        check("rise_change_only", v, 32'h00);
`else
        // Interrupt block absent: inputs still visible, IRQ space reads zero
        gpio_in = 8'hFF;
        repeat (S + 1) idle(32'h0);
        rd_op(32'h00, v);
        check("noirq_data_in", v, 32'hFF);
        wr_op(32'h0C, 8'hFF);
        rd_op(32'h0C, v);
        check("noirq_en_rd", v, 32'h00);
        rd_op(32'h14, v);
        check("noirq_stat_rd", v, 32'h00);
        check("noirq_user_irq", 32'(user_irq), 32'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            r_sel   = ($urandom_range(0, 9) != 0);
            r_rdy   = ($urandom_range(0, 9) != 0);
            r_trans = 2'($urandom);
            r_wr    = 1'($urandom);
            r_idx   = 3'($urandom);
            r_off   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            step(r_sel, r_trans, r_rdy, {27'($urandom), r_idx, r_off}, r_wr, $urandom);
        end
        idle(32'h0);

        // Reset asserted during a DATA_OUT write data phase
        step(1'b1, 2'b10, 1'b1, 32'h04, 1'b1, 32'h0);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'hAA;
        #2;
        HRESET = 1'b1;
        #1;
        model_reset();
        check("midwr_gpio_out", 32'(gpio_out), 32'h00);
        check("midwr_gpio_oeb", 32'(gpio_oeb), 32'hFF);
        check("midwr_user_irq", 32'(user_irq), 32'd0);
        check("midwr_hrdata", HRDATA, 32'h0);
        repeat (2) @(posedge HCLK);
        #4;
        HRESET = 1'b0;
        gpio_in = 8'h00;
        rd_op(32'h04, v);
        check("midwr_not_applied", v, 32'h00);
        wr_op(32'h04, 8'h33);
        check("post_rst_write", 32'(gpio_out), 32'h33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
